// File: rtl/neuron_mac_seq.sv
// Serial multiply-accumulate neuron: N_INPUTS (a, w) beats through one multiplier,
// plus bias, floor-round and saturate, then identity/ReLU/sigmoid activation.

module sigmoid #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);
    // Piecewise-linear sigmoid: evaluated on |a|, mirrored as 1 - f(|a|) for negative inputs.
    localparam logic signed [WIDTH:0] ONE   = (WIDTH+1)'(1) << FRAC;
    localparam logic signed [WIDTH:0] HALF  = (WIDTH+1)'(1) << (FRAC-1);
    localparam logic signed [WIDTH:0] K5    = (WIDTH+1)'(5) << FRAC;
    localparam logic signed [WIDTH:0] K2375 = (WIDTH+1)'(19) << (FRAC-3);
    localparam logic signed [WIDTH:0] K0844 = (WIDTH+1)'(27) << (FRAC-5);
    localparam logic signed [WIDTH:0] K0625 = (WIDTH+1)'(5) << (FRAC-3);

    logic              neg;
    logic [WIDTH:0]    ax;
    logic [WIDTH:0]    f;
    logic [WIDTH:0]    r;

    always_comb begin
        neg = a[WIDTH-1];
        ax  = neg ? ((WIDTH+1)'(0) - {a[WIDTH-1], a}) : {1'b0, a};
        if (ax >= K5)
            f = ONE;
        else if (ax >= K2375)
            f = (ax >> 5) + K0844;
        else if (ax >= ONE)
            f = (ax >> 3) + K0625;
        else
            f = (ax >> 2) + HALF;
        r = neg ? (ONE - f) : f;
        y = r[WIDTH-1:0];
    end
endmodule

module neuron_mac_seq #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 16,
    parameter int N_INPUTS = 3,
    parameter int ACT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] b_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] w_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             busy
);
    localparam int ACC_W = 2*WIDTH + $clog2(N_INPUTS) + 1;
    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ACC, RND, ACT, DONE} state_t;

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         cnt;
    logic [WIDTH-1:0]         pre;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   shifted;
    logic [WIDTH-1:0]          sat;
    logic [WIDTH-1:0]          sig_y;
    logic [WIDTH-1:0]          act_y;

    always_comb begin
        prod     = $signed(a_in) * $signed(w_in);
        prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
        bias_ext = {{(ACC_W-WIDTH){b_in[WIDTH-1]}}, b_in};
        shifted  = acc >>> FRAC;
        if (shifted > SMAX)
            sat = SMAX[WIDTH-1:0];
        else if (shifted < SMIN)
            sat = SMIN[WIDTH-1:0];
        else
            sat = shifted[WIDTH-1:0];
    end

    sigmoid #(.WIDTH(WIDTH), .FRAC(FRAC)) u_sigmoid (.a(pre), .y(sig_y));

    always_comb begin
        case (ACT_MODE)
            1:       act_y = pre[WIDTH-1] ? '0 : pre;
            2:       act_y = sig_y;
            default: act_y = pre;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            pre       <= '0;
            y         <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= bias_ext <<< FRAC;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ACC;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc <= acc + prod_ext;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            in_ready <= 1'b0;
                            state    <= RND;
                        end
                    end
                end
                RND: begin
                    pre   <= sat;
                    state <= ACT;
                end
                ACT: begin
                    y         <= act_y;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed-vector bench: identity, ReLU and sigmoid instances driven in lockstep.

module tb_neuron_mac_seq;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready;
    logic [31:0] b_in, a_in, w_in;
    logic        ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2;
    logic [31:0] y0, y1, y2;
    logic [31:0] ref_in, ref_out;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    neuron_mac_seq #(.WIDTH(32), .FRAC(16), .N_INPUTS(3), .ACT_MODE(0)) u_id (
        .clk(clk), .rst(rst), .start(start), .b_in(b_in), .in_valid(in_valid), .in_ready(ir0),
        .a_in(a_in), .w_in(w_in), .out_valid(ov0), .out_ready(out_ready), .y(y0), .busy(bz0));
    neuron_mac_seq #(.WIDTH(32), .FRAC(16), .N_INPUTS(3), .ACT_MODE(1)) u_relu (
        .clk(clk), .rst(rst), .start(start), .b_in(b_in), .in_valid(in_valid), .in_ready(ir1),
        .a_in(a_in), .w_in(w_in), .out_valid(ov1), .out_ready(out_ready), .y(y1), .busy(bz1));
    neuron_mac_seq #(.WIDTH(32), .FRAC(16), .N_INPUTS(3), .ACT_MODE(2)) u_sig (
        .clk(clk), .rst(rst), .start(start), .b_in(b_in), .in_valid(in_valid), .in_ready(ir2),
        .a_in(a_in), .w_in(w_in), .out_valid(ov2), .out_ready(out_ready), .y(y2), .busy(bz2));
    sigmoid #(.WIDTH(32), .FRAC(16)) ref_sig (.a(ref_in), .y(ref_out));

    typedef struct {
        logic [31:0]       b;
        logic [2:0][31:0]  a;
        logic [2:0][31:0]  w;
        logic [31:0]       e_id;
        logic [31:0]       e_relu;
    } vec_t;

    vec_t vt[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one evaluation; vpat gives in_valid per ACC cycle (lsb first) for npat cycles, then 1.
    task automatic run_eval(input vec_t v, input logic [7:0] vpat, input int npat,
                            input logic early_ready, input int hold);
        int idx = 0;
        int cyc = 0;
        logic acc_beat;
        logic [31:0] yh;
        out_ready = early_ready;
        b_in  = v.b;
        start = 1'b1;
        step();
        start = 1'b0;
        b_in  = 32'hDEAD_BEEF;
        chk("busy_after_start", {31'd0, bz0}, 32'd1);
        while (idx < 3 && cyc < 32) begin
            in_valid = (cyc < npat) ? vpat[cyc] : 1'b1;
            a_in = v.a[idx];
            w_in = v.w[idx];
            acc_beat = in_valid && ir0;
            step();
            if (acc_beat) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        a_in = '0;
        w_in = '0;
        if (idx < 3) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: accepted %0d beats expected 3", idx);
        end
        chk("in_ready_after_last", {31'd0, ir0}, 32'd0);
        chk("ov_low_t1", {31'd0, ov0}, 32'd0);
        step();
        chk("ov_low_t2", {31'd0, ov0}, 32'd0);
        step();
        chk("ov_high_t3", {31'd0, ov0}, 32'd1);
        chk("y_identity", y0, v.e_id);
        chk("y_relu", y1, v.e_relu);
        ref_in = v.e_id;
        #1;
        chk("y_sigmoid", y2, ref_out);
        yh = y0;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            start = i[0];
            step();
            chk("hold_ov", {31'd0, ov0}, 32'd1);
            chk("hold_busy", {31'd0, bz0}, 32'd1);
            chk("hold_y", y0, yh);
        end
        start = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ov_after_hs", {31'd0, ov0}, 32'd0);
        chk("busy_after_hs", {31'd0, bz0}, 32'd0);
        chk("y_kept_after_hs", y0, yh);
    endtask

    initial begin
        // b, a[2:0] (beat 0 in [0]), w[2:0], expected identity, expected ReLU
        vt[0] = '{32'h0000_8000, {32'h0001_0000, 32'h0001_0000, 32'h0001_0000},
                  {32'h0002_0000, 32'h0002_0000, 32'h0002_0000}, 32'h0006_8000, 32'h0006_8000};
        vt[1] = '{32'h0, {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000},
                  {32'h0001_0000, 32'h0001_0000, 32'h0001_0000}, 32'hFFFD_0000, 32'h0};
        vt[2] = '{32'h7FFF_FFFF, {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF},
                  {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF}, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        vt[3] = '{32'h0, {32'h8000_0000, 32'h8000_0000, 32'h8000_0000},
                  {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF}, 32'h8000_0000, 32'h0};
        vt[4] = '{32'h0, {32'h0, 32'h0, 32'h0}, {32'h0001_0000, 32'h0001_0000, 32'h0001_0000},
                  32'h0, 32'h0};
        // -1 + 3*1 + (-2)*1.5 + 0.5*4 = 1.0
        vt[5] = '{32'hFFFF_0000, {32'h0000_8000, 32'hFFFE_0000, 32'h0003_0000},
                  {32'h0004_0000, 32'h0001_8000, 32'h0001_0000}, 32'h0001_0000, 32'h0001_0000};
        // raw -1 in the product LSB floors to -1 LSB of y
        vt[6] = '{32'h0, {32'h0, 32'h0, 32'h0000_0001}, {32'h0, 32'h0, 32'hFFFF_FFFF},
                  32'hFFFF_FFFF, 32'h0};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        b_in = '0; a_in = '0; w_in = '0; ref_in = '0;
        step();
        step();
        chk("rst_y", y0, 32'h0);
        chk("rst_ov", {31'd0, ov0}, 32'd0);
        chk("rst_busy", {31'd0, bz0}, 32'd0);
        chk("rst_in_ready", {31'd0, ir0}, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++)
            run_eval(vt[i], 8'h00, 0, 1'b0, 0);

        // in_valid gaps 1,0,0,1,0,1 with out_ready already high
        run_eval(vt[0], 8'b10_1001, 6, 1'b1, 0);

        // backpressure for 5 cycles with start pulses during DONE
        run_eval(vt[5], 8'h00, 0, 1'b0, 5);

        // reset after two beats, with start asserted alongside
        b_in = 32'h0001_0000;
        start = 1'b1;
        step();
        start = 1'b0;
        a_in = 32'h0005_0000; w_in = 32'h0005_0000; in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        start = 1'b1;
        step();
        chk("midrst_ov", {31'd0, ov0}, 32'd0);
        chk("midrst_busy", {31'd0, bz0}, 32'd0);
        chk("midrst_y", y0, 32'h0);
        chk("midrst_in_ready", {31'd0, ir0}, 32'd0);
        rst = 1'b0;
        start = 1'b0;
        step();
        chk("post_rst_idle", {31'd0, bz0}, 32'd0);
        run_eval(vt[0], 8'h00, 0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/neuron_mac_seq.md
Name: neuron_mac_seq

Overview:
- Time-multiplexed, parametrised neuron: accumulates N_INPUTS signed fixed-point (a·w) products serially through one multiplier, adds one bias, rounds and saturates, then applies a selectable activation.
- Replaces fixed 3-input combinational neurons in the layer datapath.
- Layer controllers stream weights and activations to it over valid/ready handshakes.

Parameters:
- WIDTH, 32, data width of a, w, b and y (signed two's complement).
- FRAC, 16, fractional bits of the Q(WIDTH-FRAC).FRAC format shared by a, w, b and y.
- N_INPUTS, 3, number of (a, w) beats per evaluation; must be ≥1.
- ACT_MODE, 0, activation select: 0 identity, 1 ReLU, 2 sigmoid (codebase sigmoid unit, ports a/y, WIDTH-wide, combinational).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin evaluation; sampled only in IDLE.
- b_in  in  WIDTH  bias; captured on the accepted start.
- in_valid  in  1  a_in/w_in beat valid.
- in_ready  out  1  high only in ACC.
- a_in  in  WIDTH  activation operand.
- w_in  in  WIDTH  weight operand.
- out_valid  out  1  y valid; held until accepted.
- out_ready  in  1  downstream accepts y.
- y  out  WIDTH  activated result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset and clocking: one clock; reset is synchronous and active-high on rst. On a reset edge: state→IDLE, acc→0, cnt→0, y→0, out_valid→0, in_ready→0, busy→0. Reset mid-evaluation discards all partial work; no output is produced.
- Accumulator: ACC_W = 2·WIDTH + clog2(N_INPUTS)+1 bits, signed. Products are full 2·WIDTH-bit signed, with no intermediate truncation.
- State IDLE: when start=1, acc ← sign-extend(b_in) << FRAC and cnt ← 0, then go to ACC. In any other state start is ignored.
- State ACC: in_ready=1. Each beat with in_valid=1 adds a_in·w_in to acc and increments cnt. The beat with cnt==N_INPUTS-1 moves to RND. in_valid gaps stall without side effects.
- State RND (1 cycle):
  - Compute s = acc >>> FRAC (arithmetic shift, truncation toward −∞).
  - Saturate to [−2^(WIDTH-1), 2^(WIDTH-1)−1] and register as pre.
  - Go to ACT.
- State ACT (1 cycle):
  - Register y ← act(pre), where ReLU gives pre<0 ? 0 : pre and sigmoid drives pre into the sigmoid unit.
  - out_valid ← 1, then go to DONE.
- State DONE:
  - y and out_valid are held stable.
  - When out_ready=1, out_valid ← 0 and the state goes to IDLE on that edge.
  - A new start is accepted no earlier than the next cycle.
- Latency: last beat accepted on edge t; out_valid is high after edge t+2, i.e. 3 cycles from the last beat to a visible result. With continuous in_valid, an evaluation takes N_INPUTS+3 cycles from start to out_valid, plus 1 cycle back to IDLE.
- Edge cases:
  - N_INPUTS=1: ACC lasts exactly one accepted beat.
  - Simultaneous start and rst: rst wins.
  - out_ready high before out_valid has no effect.
  - y keeps its last value after handshake until the next ACT.

Test Plan:
- Identity, WIDTH=32/FRAC=16/N=3, continuous beats: b=0x00008000, each beat a=0x00010000, w=0x00020000 → y=0x00068000 (6.5). out_valid rises 3 cycles after the third beat.
- Negatives: ACT_MODE=0, b=0, a=0xFFFF0000 (−1.0), w=0x00010000 ×3 → y=0xFFFD0000. Same stimulus with ACT_MODE=1 → y=0x00000000.
- Saturation: a=w=0x7FFFFFFF ×3, b=0x7FFFFFFF → y=0x7FFFFFFF. a=0x80000000, w=0x7FFFFFFF ×3, b=0 → y=0x80000000.
- Handshake:
  - Gaps: in_valid toggles 1,0,0,1,0,1, giving exactly 3 accepted beats with the same result as continuous beats.
  - Backpressure: out_ready held low 5 cycles → y/out_valid stable, busy=1, and start pulses during DONE are ignored.
- Reset: rst asserted after 2 of 3 beats → next edge out_valid=0, busy=0, y=0. A fresh evaluation then yields the correct value, with no carry-over.
- Sigmoid mode (ACT_MODE=2): pre=0 (b=0, a=0 ×3) → y equals the sigmoid unit's output for input 0, checked against a direct instance of that unit.
